// File: rtl/pc.sv
// Program counter for the 16-bit fetch stage. Each enabled edge loads the
// external next address or self-increments. PC_inc feeds the next-PC/link logic.
module pc #(
   parameter int unsigned               WIDTH     = 16,
   parameter logic [WIDTH-1:0]          RESET_VEC = '0,
   parameter int unsigned               STEP      = 1
) (
   input  logic             clk,
   input  logic             PC_rst,
   input  logic             PC_en,
   input  logic             PC_load,
   input  logic [WIDTH-1:0] PC_next,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_inc,
   output logic             PC_valid
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             valid_q, valid_d;

   // PC_next is selected only on a load, so an X on it cannot leak into an increment
   always_comb begin
      pc_d    = pc_q;
      valid_d = valid_q;
      if (PC_en) begin
         pc_d    = PC_load ? PC_next : PC_inc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge PC_rst) begin
      if (!PC_rst) begin
         pc_q    <= RESET_VEC;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign PC_inc   = pc_q + STEP_W;
   assign PC       = pc_q;
   assign PC_valid = valid_q;

endmodule

// File: tb/tb_pc.sv
// Directed self-checking bench for the program counter: async reset, loads,
// increment with wrap, stall, mid-run reset and reset coinciding with an edge.
module tb_pc;

   logic        clk;
   logic        clkRun;
   logic        PC_rst;
   logic        PC_en;
   logic        PC_load;
   logic [15:0] PC_next;
   logic [15:0] PC;
   logic [15:0] PC_inc;
   logic        PC_valid;

   int assertCount;
   int failCount;

   pc dut (
      .clk      (clk),
      .PC_rst   (PC_rst),
      .PC_en    (PC_en),
      .PC_load  (PC_load),
      .PC_next  (PC_next),
      .PC       (PC),
      .PC_inc   (PC_inc),
      .PC_valid (PC_valid)
   );

   // Gated clock so the reset checks can run with the clock stopped
   initial clk = 1'b0;
   always #5 clk = clkRun ? ~clk : clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive inputs just after an edge, then sample 1 time unit after the next edge
   task automatic applyStimulus(input logic en, input logic load, input logic [15:0] nextAddr);
      PC_en   = en;
      PC_load = load;
      PC_next = nextAddr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      clkRun      = 1'b0;
      PC_rst      = 1'b1;
      PC_en       = 1'b0;
      PC_load     = 1'b0;
      PC_next     = 16'h0000;

      #1 PC_rst = 1'b0;
      #1;
      checkOutput("async_reset_pc", PC, 16'h0000);
      checkOutput("async_reset_valid", {15'd0, PC_valid}, 16'h0000);
      checkOutput("async_reset_inc", PC_inc, 16'h0001);
      PC_rst = 1'b1;
      #20;
      checkOutput("release_no_clk_pc", PC, 16'h0000);
      checkOutput("release_no_clk_valid", {15'd0, PC_valid}, 16'h0000);
      clkRun = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(1'b1, 1'b1, 16'h0001);
      checkOutput("load_0001", PC, 16'h0001);
      checkOutput("valid_after_first", {15'd0, PC_valid}, 16'h0001);
      applyStimulus(1'b1, 1'b1, 16'h0010);
      checkOutput("load_0010", PC, 16'h0010);
      applyStimulus(1'b1, 1'b1, 16'h0000);
      checkOutput("load_0000", PC, 16'h0000);
      checkOutput("inc_at_0000", PC_inc, 16'h0001);

      applyStimulus(1'b1, 1'b1, 16'hFFFE);
      checkOutput("load_fffe", PC, 16'hFFFE);
      checkOutput("inc_at_fffe", PC_inc, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 16'hxxxx);
      checkOutput("incr_ffff", PC, 16'hFFFF);
      checkOutput("inc_at_ffff", PC_inc, 16'h0000);
      applyStimulus(1'b1, 1'b0, 16'hxxxx);
      checkOutput("incr_wrap_0000", PC, 16'h0000);
      checkOutput("inc_after_wrap", PC_inc, 16'h0001);
      applyStimulus(1'b1, 1'b0, 16'hxxxx);
      checkOutput("incr_0001", PC, 16'h0001);

      applyStimulus(1'b1, 1'b1, 16'h0005);
      checkOutput("load_0005", PC, 16'h0005);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 16'h1234);
         checkOutput($sformatf("stall_%0d", i), PC, 16'h0005);
      end
      checkOutput("stall_valid", {15'd0, PC_valid}, 16'h0001);
      applyStimulus(1'b1, 1'b1, 16'h1234);
      checkOutput("reenable_1234", PC, 16'h1234);

      applyStimulus(1'b1, 1'b1, 16'h009F);
      applyStimulus(1'b1, 1'b0, 16'h0000);
      checkOutput("incr_00a0", PC, 16'h00A0);
      #2 PC_rst = 1'b0;
      #1;
      checkOutput("midrun_reset_pc", PC, 16'h0000);
      checkOutput("midrun_reset_valid", {15'd0, PC_valid}, 16'h0000);
      #1 PC_rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0000);
      checkOutput("after_release_incr", PC, 16'h0001);
      checkOutput("after_release_valid", {15'd0, PC_valid}, 16'h0001);

      PC_rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 16'hBEEF);
      checkOutput("reset_edge_pc", PC, 16'h0000);
      checkOutput("reset_edge_valid", {15'd0, PC_valid}, 16'h0000);
      PC_rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 16'hBEEF);
      checkOutput("load_beef", PC, 16'hBEEF);
      checkOutput("inc_at_beef", PC_inc, 16'hBEF0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/pc.md
Name:
pc

Overview:
- Program counter register for the fetch stage of the team's 16-bit processor.
- Holds the current instruction address and updates once per clock.
- Each update either loads an externally computed next address (branch, jump or sequential value from the next-PC logic) or self-increments.
- Drives the instruction-memory address and the PC+step value used by the next-PC/link logic.

Parameters:
- WIDTH, 16, address width in bits of PC, PC_next and PC_inc.
- RESET_VEC, 16'h0000, value PC takes while reset is asserted.
- STEP, 1, increment added for sequential fetch (PC_inc = PC + STEP).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- PC_rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- PC_en  input  1  update enable; 0 = stall, PC holds its value.
- PC_load  input  1  1 = load PC_next; 0 = increment by STEP.
- PC_next  input  WIDTH  next address, used when PC_load=1.
- PC  output  WIDTH  current program counter, registered.
- PC_inc  output  WIDTH  combinational PC + STEP, modulo 2^WIDTH.
- PC_valid  output  1  registered; 0 during reset, 1 from the first enabled update after reset release.

Behaviour:
- Reset:
  - PC_rst=0 forces PC=RESET_VEC and PC_valid=0 immediately, independent of clk.
  - Both are held while PC_rst=0.
- Reset release:
  - Deassertion takes effect on the next rising edge.
  - No update occurs on an edge that coincides with PC_rst=0.
- Update priority on each rising edge with PC_rst=1:
  1. PC_en=0: PC and PC_valid hold.
  2. PC_en=1 and PC_load=1: PC <= PC_next; PC_valid <= 1.
  3. PC_en=1 and PC_load=0: PC <= PC + STEP, modulo 2^WIDTH; PC_valid <= 1.
- Latency: one cycle. A PC_next value presented before an enabled edge appears on PC immediately after that edge.
- PC_inc:
  - Purely combinational from PC; updates in the same delta as PC changes.
  - Wraps: PC=16'hFFFF, STEP=1 gives PC_inc=16'h0000.
- Wrap-around: increment past the top address wraps to 0. No flag, no saturation.
- PC_next is loaded unmodified; there is no alignment or masking.
- PC_next and PC_load are ignored while PC_en=0 or while reset is asserted.
- Reset asserted mid-operation, including between edges: PC returns to RESET_VEC at once. The next enabled edge after release starts from RESET_VEC.
- No internal state other than PC and PC_valid. No X propagation from PC_next when PC_load=0.

Test Plan:
- Async reset: with clk stopped, drive PC_rst=0 -> PC=16'h0000 and PC_valid=0 within the same timestep. Release to 1 -> values unchanged until the next edge.
- Load sequence: PC_en=1, PC_load=1, PC_next=0001, then 0010, then 0000 on successive edges -> PC=0001, 0010, 0000 after each edge. PC_valid=1 after the first edge.
- Increment and wrap:
  - Load 16'hFFFE, then PC_load=0 for 3 edges -> PC=FFFF, 0000, 0001.
  - PC_inc reads FFFF, 0000, 0001 when PC is FFFE, FFFF, 0000.
- Stall: PC=0005, PC_en=0 for 4 edges with PC_load=1, PC_next=1234 -> PC stays 0005. Re-enable -> PC=1234 one edge later.
- Reset mid-run: PC=00A0 while incrementing. Pull PC_rst=0 between edges -> PC=0000 immediately. Release -> first enabled increment edge gives 0001.
- Simultaneous reset and edge: PC_rst=0 held across a rising edge with PC_en=1, PC_load=1, PC_next=BEEF -> PC remains 0000 and PC_valid remains 0.
